// File: rtl/rr_eight_way_arbiter.sv
// rr_eight_way_arbiter
//   Round-robin arbiter sharing one RV_BIT_NUM-bit channel among 8 requesters.
//   The grant is combinational. The granted word and its index are registered
//   and presented downstream on a valid/ready output stage.
//   Optional build macro: RR_ARB_LOCK_EN adds a lock[7:0] input. A locked
//   requester keeps winning for as long as it keeps requesting.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   last_ptr  | index of the most recent grant; round-robin scan starts at +1
//   out_valid | output register holds a beat not yet taken by the consumer
//   locked    | (lock build) lk_ptr holds priority over round-robin order

module rr_eight_way_arbiter #(
    parameter int RV_BIT_NUM = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              req,
    input  logic [8*RV_BIT_NUM-1:0] d,
`ifdef RR_ARB_LOCK_EN
    input  logic [7:0]              lock,
`endif
    output logic [7:0]              gnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RV_BIT_NUM-1:0]   out_q,
    output logic [2:0]              out_sel
);

    logic [2:0]            last_ptr;
    logic                  load;
    logic                  any_req;
    logic                  rr_found;
    logic [2:0]            rr_idx;
    logic [2:0]            cand;
    logic [2:0]            win_idx;
    logic [RV_BIT_NUM-1:0] d_word [8];

    assign load    = ~out_valid | out_ready;
    assign any_req = |req;

    // Split the packed input bus into one word per requester.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            d_word[i] = d[i*RV_BIT_NUM +: RV_BIT_NUM];
        end
    end

    // Round-robin scan: last_ptr+1 ... last_ptr+8. The wrap is modulo 8, so the
    // last requester granted is checked last and wins only when it is alone.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_ptr;
        cand     = last_ptr;
        for (int k = 1; k <= 8; k++) begin
            cand = last_ptr + 3'(k);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    logic       locked;
    logic [2:0] lk_ptr;
    logic       lock_hit;

    assign lock_hit = locked & req[lk_ptr];
    assign win_idx  = lock_hit ? lk_ptr : rr_idx;

    // Lock tracking: the lock bit of each granted beat decides whether its
    // requester keeps priority. A load on which the locked requester is not
    // requesting releases the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            lk_ptr <= 3'd0;
        end else if (load) begin
            if (any_req) begin
                locked <= lock[win_idx];
                lk_ptr <= win_idx;
            end else begin
                locked <= 1'b0;
            end
        end
    end
`else
    assign win_idx = rr_idx;
`endif

    // Grant only when the output register can accept a beat. The grant is
    // held low during reset.
    always_comb begin
        gnt = 8'h00;
        if (!rst && load && any_req) begin
            gnt = 8'(1) << win_idx;
        end
    end

    // Output register and pointer. A stall holds everything. A drain with no
    // request empties the register but keeps the pointer and the last data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_sel   <= 3'd0;
            last_ptr  <= 3'd7;
        end else if (load) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_q     <= d_word[win_idx];
                out_sel   <= win_idx;
                last_ptr  <= win_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_eight_way_arbiter.sv
// Directed testbench for rr_eight_way_arbiter. Expected values are hand-derived.
// Define RR_ARB_LOCK_EN to exercise the lock feature.

module tb_rr_eight_way_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     req;
    logic [8*W-1:0] d;
    logic [7:0]     gnt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_q;
    logic [2:0]     out_sel;
`ifdef RR_ARB_LOCK_EN
    logic [7:0]     lock;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    rr_eight_way_arbiter #(.RV_BIT_NUM(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d         (d),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lock      = 8'h00;
`endif
        for (int i = 0; i < 8; i++) d[i*W +: W] = 32'hA0 + 32'(i);

        // Reset held for two cycles with every requester active
        tick();
        chk("rst_gnt0", 32'(gnt), 32'h00);
        tick();
        chk("rst_gnt1", 32'(gnt), 32'h00);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_q", out_q, 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        rst = 1'b0;
        settle();
        chk("first_gnt", 32'(gnt), 32'h01);
        tick();
        chk("first_sel", 32'(out_sel), 32'h0);
        chk("first_q", out_q, 32'hA0);
        chk("first_valid", 32'(out_valid), 32'h1);

        // Fairness and wrap: grants go 1..7 then 0, 1
        for (int k = 1; k <= 9; k++) begin
            chk("rr_gnt", 32'(gnt), 32'(8'(1) << (k % 8)));
            tick();
            chk("rr_sel", 32'(out_sel), 32'(k % 8));
            chk("rr_q", out_q, 32'hA0 + 32'(k % 8));
        end

        // Wrap skip: make last_ptr 6, then with req 7 and 0 the grants go 7 then 0
        req = 8'h40;
        settle();
        chk("ws_gnt6", 32'(gnt), 32'h40);
        tick();
        chk("ws_sel6", 32'(out_sel), 32'h6);
        req = 8'b1000_0001;
        settle();
        chk("ws_gnt7", 32'(gnt), 32'h80);
        tick();
        chk("ws_sel7", 32'(out_sel), 32'h7);
        chk("ws_q7", out_q, 32'hA7);
        chk("ws_gnt0", 32'(gnt), 32'h01);
        tick();
        chk("ws_sel0", 32'(out_sel), 32'h0);
        req = 8'h01;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("solo_gnt", 32'(gnt), 32'h01);
            tick();
            chk("solo_sel", 32'(out_sel), 32'h0);
            chk("solo_valid", 32'(out_valid), 32'h1);
        end

        // Backpressure: load A3, stall for three cycles, then release
        req = 8'h08;
        settle();
        chk("bp_gnt3", 32'(gnt), 32'h08);
        tick();
        chk("bp_q", out_q, 32'hA3);
        out_ready = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_gnt_stall", 32'(gnt), 32'h00);
            tick();
            chk("bp_q_hold", out_q, 32'hA3);
            chk("bp_sel_hold", 32'(out_sel), 32'h3);
            chk("bp_valid_hold", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_gnt", 32'(gnt), 32'h10);
        tick();
        chk("bp_release_sel", 32'(out_sel), 32'h4);
        chk("bp_release_q", out_q, 32'hA4);
        chk("bp_release_valid", 32'(out_valid), 32'h1);

        // Idle drain: one beat from req2, then no requests
        req = 8'h04;
        settle();
        chk("dr_gnt2", 32'(gnt), 32'h04);
        tick();
        chk("dr_sel2", 32'(out_sel), 32'h2);
        chk("dr_valid1", 32'(out_valid), 32'h1);
        req = 8'h00;
        settle();
        chk("dr_gnt_none", 32'(gnt), 32'h00);
        tick();
        chk("dr_valid0", 32'(out_valid), 32'h0);
        chk("dr_sel_hold", 32'(out_sel), 32'h2);
        chk("dr_q_hold", out_q, 32'hA2);
        req = 8'hFF;
        settle();
        chk("dr_ptr_next", 32'(gnt), 32'h08);
        tick();
        chk("dr_sel3", 32'(out_sel), 32'h3);

        // Reset mid-operation discards the pending beat and resets the pointer
        out_ready = 1'b0;
        rst = 1'b1;
        settle();
        chk("mr_gnt", 32'(gnt), 32'h00);
        tick();
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_q", out_q, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("mr_first_gnt", 32'(gnt), 32'h01);
        tick();
        chk("mr_first_sel", 32'(out_sel), 32'h0);

`ifdef RR_ARB_LOCK_EN
        // Lock: req1 holds priority over req2 until it sends a beat with lock=0
        req  = 8'h06;
        lock = 8'h02;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) lock = 8'h00;
            settle();
            chk("lk_gnt1", 32'(gnt), 32'h02);
            tick();
            chk("lk_sel1", 32'(out_sel), 32'h1);
        end
        settle();
        chk("lk_gnt2", 32'(gnt), 32'h04);
        tick();
        chk("lk_sel2", 32'(out_sel), 32'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
